wb_pipeline_master: RTL

WB_PIPELINE_MASTER -- requirements
Module: wb_pipeline_master

---
 rtl/wb_pipeline_master_if.sv | 45 ++++
 rtl/wb_pipeline_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipeline_master_if.sv
// Pipelined Wishbone bus bundle between a master and the interconnect/slave.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 4
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

interface wb_pipeline_master_if #(
    parameter int unsigned BUS_DATA_WIDTH    = `BUS_DATA_WIDTH,
    parameter int unsigned BUS_ADDRESS_WIDTH = `BUS_ADDRESS_WIDTH,
    parameter int unsigned BUS_TGA_WIDTH     = `BUS_TGA_WIDTH,
    parameter int unsigned BUS_TGC_WIDTH     = `BUS_TGC_WIDTH
);
    logic                           CYC_O;
    logic                           STB_O;
    logic                           WE_O;
    logic [BUS_ADDRESS_WIDTH-1:0]   ADR_O;
    logic [BUS_DATA_WIDTH-1:0]      DAT_O;
    logic [BUS_DATA_WIDTH/8-1:0]    SEL_O;
    logic [BUS_TGA_WIDTH-1:0]       TGA_O;
    logic [BUS_TGC_WIDTH-1:0]       TGC_O;
    logic [2:0]                     CTI_O;
    logic                           ACK_I;
    logic                           RTY_I;
    logic                           ERR_I;
    logic                           STALL_I;
    logic [BUS_DATA_WIDTH-1:0]      DAT_I;

    modport master (
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, CTI_O,
        input  ACK_I, RTY_I, ERR_I, STALL_I, DAT_I
    );

    modport slave (
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, CTI_O,
        output ACK_I, RTY_I, ERR_I, STALL_I, DAT_I
    );
endinterface

// File: rtl/wb_pipeline_master.sv
// Pipelined Wishbone master: issues a burst of same-address beats, counts ACKs,
// aborts on ERR/RTY or ACK timeout, and reports completion with done_o/err_o.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 4
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

module wb_pipeline_master #(
    parameter int unsigned MAX_BEATS         = 8,
    parameter int unsigned ACK_TIMEOUT       = 64,
    parameter int unsigned BUS_DATA_WIDTH    = `BUS_DATA_WIDTH,
    parameter int unsigned BUS_ADDRESS_WIDTH = `BUS_ADDRESS_WIDTH,
    parameter int unsigned BUS_TGA_WIDTH     = `BUS_TGA_WIDTH,
    parameter int unsigned BUS_TGC_WIDTH     = `BUS_TGC_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]    adr_i,
    input  logic [BUS_TGA_WIDTH-1:0]        tga_i,
    input  logic [BUS_TGC_WIDTH-1:0]        tgc_i,
    input  logic [$clog2(MAX_BEATS):0]      n_beats_i,
    input  logic [BUS_DATA_WIDTH-1:0]       wr_data_i,
    output logic                            wr_pop_o,
    output logic [BUS_DATA_WIDTH-1:0]       rd_data_o,
    output logic                            rd_valid_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    input  logic                            gnt_wb_i,
    wb_pipeline_master_if.master            wb
);
    localparam int unsigned NBW = $clog2(MAX_BEATS) + 1;
    localparam int unsigned TOW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic                           cyc_q, cyc_d;
    logic                           stb_q, stb_d;
    logic                           we_q, we_d;
    logic [BUS_ADDRESS_WIDTH-1:0]   adr_q, adr_d;
    logic [BUS_TGA_WIDTH-1:0]       tga_q, tga_d;
    logic [BUS_TGC_WIDTH-1:0]       tgc_q, tgc_d;
    logic [NBW-1:0]                 nb_q, nb_d;
    logic [NBW-1:0]                 iss_q, iss_d;
    logic [NBW-1:0]                 ack_q, ack_d;
    logic [TOW-1:0]                 to_q, to_d;
    logic                           err_q, err_d;
    logic                           rd_valid_q, rd_valid_d;
    logic [BUS_DATA_WIDTH-1:0]      rd_data_q, rd_data_d;

    logic                           accept;
    logic                           ack_ok;
    logic                           bus_err;
    logic                           timeout;
    logic [NBW-1:0]                 iss_nxt;
    logic [NBW-1:0]                 ack_nxt;

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        tga_d      = tga_q;
        tgc_d      = tgc_q;
        nb_d       = nb_q;
        iss_d      = iss_q;
        ack_d      = ack_q;
        to_d       = to_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        accept  = stb_q & ~wb.STALL_I;
        // An ACK only counts against a beat that has already been accepted
        ack_ok  = cyc_q & wb.ACK_I & (ack_q < iss_q);
        bus_err = cyc_q & (wb.ERR_I | wb.RTY_I);
        timeout = ((state_q == S_ISSUE) || (state_q == S_WAIT_ACK)) &&
                  (to_q == TOW'(ACK_TIMEOUT));
        iss_nxt = iss_q + NBW'(accept);
        ack_nxt = ack_q + NBW'(ack_ok);

        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_REQ;
                    cyc_d   = 1'b1;
                    we_d    = we_i;
                    adr_d   = adr_i;
                    tga_d   = tga_i;
                    tgc_d   = tgc_i;
                    iss_d   = '0;
                    ack_d   = '0;
                    to_d    = '0;
                    err_d   = 1'b0;
                    if (n_beats_i == '0)
                        nb_d = NBW'(1);
                    else if (n_beats_i > NBW'(MAX_BEATS))
                        nb_d = NBW'(MAX_BEATS);
                    else
                        nb_d = n_beats_i;
                end
            end
            S_REQ: begin
                if (bus_err) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (gnt_wb_i) begin
                    state_d = S_ISSUE;
                    stb_d   = 1'b1;
                    to_d    = '0;
                end
            end
            S_ISSUE, S_WAIT_ACK: begin
                iss_d = iss_nxt;
                ack_d = ack_nxt;
                to_d  = ack_ok ? '0 : to_q + TOW'(1);
                if (bus_err || timeout) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    rd_valid_d = ack_ok & ~we_q;
                    if (ack_ok && !we_q)
                        rd_data_d = wb.DAT_I;
                    if (ack_nxt == nb_q) begin
                        state_d = S_DONE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end else if (accept && (iss_nxt == nb_q)) begin
                        state_d = S_WAIT_ACK;
                        stb_d   = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            tga_q      <= '0;
            tgc_q      <= '0;
            nb_q       <= '0;
            iss_q      <= '0;
            ack_q      <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            tga_q      <= tga_d;
            tgc_q      <= tgc_d;
            nb_q       <= nb_d;
            iss_q      <= iss_d;
            ack_q      <= ack_d;
            to_q       <= to_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Write data and pop must track the live STALL_I, so they are not registered
    assign wr_pop_o   = accept & we_q;
    assign wb.DAT_O   = (cyc_q && we_q) ? wr_data_i : '0;

    assign wb.CYC_O   = cyc_q;
    assign wb.STB_O   = stb_q;
    assign wb.WE_O    = we_q;
    assign wb.ADR_O   = adr_q;
    assign wb.TGA_O   = tga_q;
    assign wb.TGC_O   = tgc_q;
    assign wb.SEL_O   = {(BUS_DATA_WIDTH/8){cyc_q}};
    assign wb.CTI_O   = 3'b000;

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_DONE) & err_q;
endmodule
